// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the FSM state encoding, the requester (owner) encoding, address and
// wait-counter widths, and the data-word width helper.
package dmem_arb_pkg;

    // Memory address width; 256 entries
    localparam int unsigned ADDR_W = 8;

    // Width of the host starvation counter and its saturation value
    localparam int unsigned WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_SAT = 4'd15;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Which requester owns the transaction in flight
    typedef enum logic {
        OWN_C = 1'b0,
        OWN_H = 1'b1
    } owner_e;

    // Data word width: one byte per RNS domain
    function automatic int unsigned dw_of(input int unsigned num_domains);
        return num_domains * 8;
    endfunction

endpackage

// File: rtl/dmem_fwd_buf.sv
// Last-write forwarding buffer for the data memory.
// The memory read port only re-evaluates when its address changes, so a load
// from the address that was just written (with the read address unchanged)
// would see stale data. This block remembers the last store and substitutes
// its data on an address hit.
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   wr_en       a store is being issued to memory this cycle
//   wr_addr     store address
//   wr_data     store data
//   rd_drive    a load is driving its address onto the memory read port
//   rd_addr     address of the load in flight (invalidate compare and lookup)
//   mem_data    combinational read data from the memory
//   rd_data_c   selected read data (forwarded or memory), combinational
module dmem_fwd_buf
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_drive,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DW-1:0]     mem_data,
    output logic [DW-1:0]     rd_data_c
);

    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DW-1:0]     fwd_data;
    logic              hit_c;

    // Capture every store; drop the entry once the memory has been made to
    // re-evaluate by a read-address change away from the forwarded address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else if (wr_en) begin
            fwd_valid <= 1'b1;
            fwd_addr  <= wr_addr;
            fwd_data  <= wr_data;
        end else if (rd_drive && (rd_addr != fwd_addr)) begin
            fwd_valid <= 1'b0;
        end
    end

    // Hit compare and read-data select
    assign hit_c     = fwd_valid && (fwd_addr == rd_addr);
    assign rd_data_c = hit_c ? fwd_data : mem_data;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store unit (port C) and the
// host/debug loader (port H). Serialises one transaction at a time through
// IDLE -> ACCESS (-> RESP for loads) and drives the memory's read address,
// write address, write data and store strobe. All outputs are registered.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata    core request, held until c_gnt
//   c_gnt, c_rvalid, c_rdata     core grant pulse, load-data pulse and data
//   h_req/h_we/h_addr/h_wdata    host request, held until h_gnt
//   h_gnt, h_rvalid, h_rdata     host grant pulse, load-data pulse and data
//   data_rd_addr          memory read address (held between loads)
//   data_wr_addr          memory write address
//   datamem_wr_data       memory write data
//   store_to_mem          memory write enable, sampled by memory on posedge
//   dmem_dout             combinational memory read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter  int unsigned NUM_DOMAINS = 1,
    parameter  int unsigned MAX_WAIT    = 4,
    localparam int unsigned DW          = dw_of(NUM_DOMAINS)
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [7:0]    c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,

    input  logic          h_req,
    input  logic          h_we,
    input  logic [7:0]    h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,

    output logic [7:0]    data_rd_addr,
    output logic [7:0]    data_wr_addr,
    output logic [DW-1:0] datamem_wr_data,
    output logic          store_to_mem,
    input  logic [DW-1:0] dmem_dout
);

    state_e            state;
    owner_e            owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DW-1:0]     wdata_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic              h_wins_c;
    logic              fwd_wr_c;
    logic              fwd_rd_c;
    logic [DW-1:0]     rd_data_c;

    // Core wins by default; host wins when alone or once it has been
    // passed over MAX_WAIT times in a row.
    assign h_wins_c = h_req && (!c_req || (wait_cnt >= WAIT_W'(MAX_WAIT)));

    // Forwarding buffer updates alongside the registered memory controls
    assign fwd_wr_c = (state == ACCESS) && we_q;
    assign fwd_rd_c = (state == ACCESS) && !we_q;

    dmem_fwd_buf #(
        .DW (DW)
    ) u_fwd_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (fwd_wr_c),
        .wr_addr   (addr_q),
        .wr_data   (wdata_q),
        .rd_drive  (fwd_rd_c),
        .rd_addr   (addr_q),
        .mem_data  (dmem_dout),
        .rd_data_c (rd_data_c)
    );

    // Arbiter FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            owner_q         <= OWN_C;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wait_cnt        <= '0;
            c_gnt           <= 1'b0;
            h_gnt           <= 1'b0;
            c_rvalid        <= 1'b0;
            h_rvalid        <= 1'b0;
            c_rdata         <= '0;
            h_rdata         <= '0;
            data_rd_addr    <= '0;
            data_wr_addr    <= '0;
            datamem_wr_data <= '0;
            store_to_mem    <= 1'b0;
        end else begin
            // Pulses default low every cycle
            c_gnt        <= 1'b0;
            h_gnt        <= 1'b0;
            c_rvalid     <= 1'b0;
            h_rvalid     <= 1'b0;
            store_to_mem <= 1'b0;

            case (state)
                IDLE: begin
                    if (c_req || h_req) begin
                        state <= ACCESS;
                        if (h_wins_c) begin
                            owner_q  <= OWN_H;
                            we_q     <= h_we;
                            addr_q   <= h_addr;
                            wdata_q  <= h_wdata;
                            h_gnt    <= 1'b1;
                            wait_cnt <= '0;
                        end else begin
                            owner_q <= OWN_C;
                            we_q    <= c_we;
                            addr_q  <= c_addr;
                            wdata_q <= c_wdata;
                            c_gnt   <= 1'b1;
                            // Host lost this round while asking
                            if (h_req && (wait_cnt != WAIT_SAT)) begin
                                wait_cnt <= wait_cnt + WAIT_W'(1);
                            end
                        end
                    end
                end

                ACCESS: begin
                    if (we_q) begin
                        store_to_mem    <= 1'b1;
                        data_wr_addr    <= addr_q;
                        datamem_wr_data <= wdata_q;
                        state           <= IDLE;
                    end else begin
                        // Read address is left in place after the load
                        data_rd_addr <= addr_q;
                        state        <= RESP;
                    end
                end

                RESP: begin
                    if (owner_q == OWN_H) begin
                        h_rdata  <= rd_data_c;
                        h_rvalid <= 1'b1;
                    end else begin
                        c_rdata  <= rd_data_c;
                        c_rvalid <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned ND   = 2;
    localparam int unsigned DW   = 16;
    localparam int unsigned MAXW = 4;

    logic          clk;
    logic          reset;
    logic          c_req, c_we, h_req, h_we;
    logic [7:0]    c_addr, h_addr;
    logic [DW-1:0] c_wdata, h_wdata;
    logic          c_gnt, c_rvalid, h_gnt, h_rvalid;
    logic [DW-1:0] c_rdata, h_rdata;
    logic [7:0]    data_rd_addr, data_wr_addr;
    logic [DW-1:0] datamem_wr_data, dmem_dout;
    logic          store_to_mem;

    dmem_arbiter #(
        .NUM_DOMAINS (ND),
        .MAX_WAIT    (MAXW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .c_req           (c_req),
        .c_we            (c_we),
        .c_addr          (c_addr),
        .c_wdata         (c_wdata),
        .c_gnt           (c_gnt),
        .c_rvalid        (c_rvalid),
        .c_rdata         (c_rdata),
        .h_req           (h_req),
        .h_we            (h_we),
        .h_addr          (h_addr),
        .h_wdata         (h_wdata),
        .h_gnt           (h_gnt),
        .h_rvalid        (h_rvalid),
        .h_rdata         (h_rdata),
        .data_rd_addr    (data_rd_addr),
        .data_wr_addr    (data_wr_addr),
        .datamem_wr_data (datamem_wr_data),
        .store_to_mem    (store_to_mem),
        .dmem_dout       (dmem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: either ideal combinational read, or a read port that
    // only refreshes on a read-address change (the real device's behaviour).
    logic [DW-1:0] mem [256];
    logic [DW-1:0] dout_snap;
    logic          mem_ideal;

    always @(posedge clk) if (store_to_mem) mem[data_wr_addr] <= datamem_wr_data;
    always @(data_rd_addr) dout_snap = mem[data_rd_addr];
    assign dmem_dout = mem_ideal ? mem[data_rd_addr] : dout_snap;

    // Reference model: memory contents in grant order
    logic [DW-1:0] ref_mem [256];

    typedef struct packed {
        logic [7:0]    a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           st_q[$];
    logic [DW-1:0] c_ld_q[$];
    logic [DW-1:0] h_ld_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations when the DUT presents a write or load data
    always @(negedge clk) begin
        if (!reset) begin
            if (c_gnt || h_gnt) check("gnt_exclusive", 32'(c_gnt & h_gnt), 32'd0);
            if (store_to_mem) begin
                if (st_q.size() == 0) check("unexpected_store", 32'd1, 32'd0);
                else begin
                    wr_t w;
                    w = st_q.pop_front();
                    check("wr_addr", 32'(data_wr_addr), 32'(w.a));
                    check("wr_data", 32'(datamem_wr_data), 32'(w.d));
                end
            end
            if (c_rvalid) begin
                if (c_ld_q.size() == 0) check("unexpected_c_rvalid", 32'd1, 32'd0);
                else check("c_rdata", 32'(c_rdata), 32'(c_ld_q.pop_front()));
            end
            if (h_rvalid) begin
                if (h_ld_q.size() == 0) check("unexpected_h_rvalid", 32'd1, 32'd0);
                else check("h_rdata", 32'(h_rdata), 32'(h_ld_q.pop_front()));
            end
        end
    end

    // Issue one request and wait for its grant; record the expected outcome.
    // Called and returns at 1 time unit after a rising edge.
    task automatic xfer(input bit ph, input bit we, input logic [7:0] addr,
                        input logic [DW-1:0] wd, output int cyc);
        bit g;
        if (ph) begin h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = wd; end
        else    begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wd; end
        cyc = 0;
        g   = 1'b0;
        while (!g && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            g = ph ? h_gnt : c_gnt;
        end
        if (ph) h_req = 1'b0; else c_req = 1'b0;
        if (!g) begin
            check("gnt_timeout", 32'd1, 32'd0);
        end else if (we) begin
            ref_mem[addr] = wd;
            st_q.push_back(wr_t'{addr, wd});
        end else if (ph) begin
            h_ld_q.push_back(ref_mem[addr]);
        end else begin
            c_ld_q.push_back(ref_mem[addr]);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((st_q.size() + c_ld_q.size() + h_ld_q.size()) != 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_pending", 32'(st_q.size() + c_ld_q.size() + h_ld_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] rand_addr();
        logic [7:0] a;
        a = 8'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) a = a | 8'hF0;
        return a;
    endfunction

    task automatic rand_port(input bit ph, input int n);
        int cyc;
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #1; end
            xfer(ph, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom), cyc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        int  k;
        int  g;
        int  hw;
        bit  exp_h;
        logic seen;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        dout_snap = '0;
        mem_ideal = 1'b0;
        reset = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_gnt",      32'({c_gnt, h_gnt}), 32'd0);
        check("rst_rvalid",   32'({c_rvalid, h_rvalid}), 32'd0);
        check("rst_store",    32'(store_to_mem), 32'd0);
        check("rst_rd_addr",  32'(data_rd_addr), 32'd0);
        check("rst_wr_addr",  32'(data_wr_addr), 32'd0);
        check("rst_wr_data",  32'(datamem_wr_data), 32'd0);
        check("rst_rdata",    32'({c_rdata, h_rdata}), 32'd0);
        check("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);

        // Core store, grant one cycle after request
        xfer(1'b0, 1'b1, 8'h10, 16'h00A5, cyc);
        check("store_gnt_latency", 32'(cyc), 32'd1);
        drain();

        // Forwarding: read address already at 0x10, memory port stays stale
        xfer(1'b0, 1'b0, 8'h10, '0, cyc);
        drain();
        check("rd_addr_pre", 32'(data_rd_addr), 32'h10);
        xfer(1'b0, 1'b1, 8'h10, 16'h003C, cyc);
        xfer(1'b0, 1'b0, 8'h10, '0, cyc);
        k = 0;
        while (!c_rvalid && k < 20) begin @(posedge clk); #1; k++; end
        check("load_rvalid_latency", 32'(k), 32'd2);
        drain();

        // Arbitration under continuous contention
        c_we = 1'b1; h_we = 1'b1;
        c_addr = 8'h20; h_addr = 8'h40;
        c_wdata = 16'($urandom); h_wdata = 16'($urandom);
        c_req = 1'b1; h_req = 1'b1;
        hw = 0; g = 0; k = 0;
        while (g < 10 && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (c_gnt || h_gnt) begin
                exp_h = (hw >= int'(MAXW));
                check("arb_grant_h", 32'(h_gnt), 32'(exp_h));
                if (exp_h) hw = 0; else if (hw < 15) hw++;
                if (h_gnt) begin
                    check("wait_clear", 32'(dut.wait_cnt), 32'd0);
                    ref_mem[h_addr] = h_wdata;
                    st_q.push_back(wr_t'{h_addr, h_wdata});
                    h_addr  = h_addr + 8'd1;
                    h_wdata = 16'($urandom);
                end else begin
                    ref_mem[c_addr] = c_wdata;
                    st_q.push_back(wr_t'{c_addr, c_wdata});
                    c_addr  = c_addr + 8'd1;
                    c_wdata = 16'($urandom);
                end
                g++;
            end
        end
        c_req = 1'b0; h_req = 1'b0;
        check("arb_grant_count", 32'(g), 32'd10);
        drain();

        // Host preload and inspect at the address extremes
        xfer(1'b1, 1'b1, 8'hFF, 16'h0011, cyc);
        xfer(1'b1, 1'b1, 8'h00, 16'h0022, cyc);
        xfer(1'b1, 1'b0, 8'hFF, '0, cyc);
        xfer(1'b1, 1'b0, 8'h00, '0, cyc);
        drain();

        // Two-domain word written by core, read by host
        xfer(1'b0, 1'b1, 8'h05, 16'h1234, cyc);
        drain();
        xfer(1'b1, 1'b0, 8'h05, '0, cyc);
        drain();

        // Reset while the store strobe is asserted
        c_req = 1'b1; c_we = 1'b1; c_addr = 8'h30; c_wdata = 16'hBEEF;
        k = 0;
        while (!c_gnt && k < 20) begin @(posedge clk); #1; k++; end
        c_req = 1'b0;
        check("rst_test_gnt", 32'(c_gnt), 32'd1);
        @(posedge clk); #1;
        check("rst_test_strobe", 32'(store_to_mem), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_async_strobe", 32'(store_to_mem), 32'd0);
        check("rst_async_state", 32'(dut.state), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            seen = seen | c_gnt | c_rvalid | store_to_mem;
        end
        check("rst_no_activity", 32'(seen), 32'd0);
        check("rst_mem_unchanged", 32'(mem[8'h30]), 32'(ref_mem[8'h30]));

        // Randomised concurrent traffic against an ideal memory
        mem_ideal = 1'b1;
        fork
            rand_port(1'b0, 60);
            rand_port(1'b1, 60);
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port-per-direction data memory (256 entries x NUM_DOMAINS bytes) between two requesters: the core load/store unit (port C) and the host/debug loader (port H).
- Serialises accesses through a 3-state FSM and drives the memory's read address, write address, write data and store strobe.
- The memory read is combinational and re-evaluates only on a read-address *change*, so the block forwards data from the last write.
- Sits between the core pipeline and the data memory; the host port is used for preload and inspection of RNS operands.

Parameters:
- NUM_DOMAINS, 1, number of RNS domains; data word width DW = NUM_DOMAINS*8.
- MAX_WAIT, 4, number of consecutive cycles H may lose arbitration before it gets forced priority (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- c_req  in  1  core request; held with payload until c_gnt.
- c_we  in  1  1 = store, 0 = load.
- c_addr  in  8  core address.
- c_wdata  in  DW  core store data, {Domain1,...,DomainN}.
- c_gnt  out  1  one-cycle pulse: request accepted, payload latched.
- c_rvalid  out  1  one-cycle pulse: load data valid on c_rdata.
- c_rdata  out  DW  load data; holds its value until the next c_rvalid.
- h_req, h_we, h_addr, h_wdata, h_gnt, h_rvalid, h_rdata  same as the core port, for the host.
- data_rd_addr  out  8  to memory read address.
- data_wr_addr  out  8  to memory write address.
- datamem_wr_data  out  DW  to memory write data.
- store_to_mem  out  1  to memory write enable; the memory samples it on posedge.
- dmem_dout  in  DW  from memory read data (combinational).

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - All gnt/rvalid = 0; store_to_mem = 0.
  - data_rd_addr = data_wr_addr = 0; datamem_wr_data = 0; c_rdata = h_rdata = 0.
  - wait_cnt = 0; fwd_valid = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on posedge with any req:
  - Pick the winner; latch own_q, we_q, addr_q, wdata_q.
  - Pulse the winner's gnt for the next cycle and go to ACCESS.
  - If no req, stay in IDLE.
- Arbitration:
  - C wins by default.
  - H wins if only H requests, or if both request and wait_cnt >= MAX_WAIT.
  - Grants are never simultaneous.
- wait_cnt:
  - Increments (saturating at 15) on each IDLE arbitration H loses while h_req = 1.
  - Clears on any H grant.
- ACCESS (1 cycle):
  - Store: store_to_mem = 1 and data_wr_addr / datamem_wr_data = addr_q / wdata_q for exactly this cycle. Set fwd_addr = addr_q, fwd_data = wdata_q, fwd_valid = 1. Return to IDLE.
  - Load: data_rd_addr = addr_q (held after this, never returned to 0). Go to RESP.
- RESP:
  - Read data = fwd_data if fwd_valid and fwd_addr == addr_q; otherwise dmem_dout.
  - Register the read data into the owner's rdata and pulse the owner's rvalid for one cycle. Return to IDLE.
- Latency: store takes 2 cycles (gnt to memory write); load takes 3 cycles (request sampled to rvalid).
- Maximum throughput is one transaction per 2 cycles (store) or 3 cycles (load).
- Forwarding invalidation: fwd_valid clears when a load drives a data_rd_addr that differs from fwd_addr, because the memory then re-evaluates on the address change.
- Boundary conditions:
  - Address wrap: addresses are 8-bit; there is no carry and no range error, so 0xFF and 0x00 are both legal.
  - Requests during ACCESS/RESP are ignored until the next IDLE sample; the requester keeps req high.
  - Dropping req before gnt is legal; nothing is issued.
  - Reset mid-operation forces IDLE immediately and deasserts store_to_mem asynchronously. The pending transaction is discarded with no gnt/rvalid; the requester must re-issue.
  - Back-to-back load of the same address with no intervening store returns dmem_dout, which is unchanged and therefore correct.

Decomposition:
- Package dmem_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), owner encoding (OWN_C=0, OWN_H=1), DW computation, WAIT_W=4.
- One sub-module, dmem_fwd_buf: last-write address/data/valid register plus hit compare; outputs the selected read data.

Test Plan:
- Reset, then C store addr 0x10 data 0xA5 -> c_gnt at cycle 1; store_to_mem = 1 with wr_addr 0x10, wr_data 0xA5 for one cycle; no rvalid.
- C store 0x10 = 0x3C, then C load 0x10 with data_rd_addr already 0x10 -> c_rvalid after 3 cycles, c_rdata = 0x3C via forwarding.
- c_req and h_req held continuously, MAX_WAIT = 4 -> grant sequence C,C,C,C,H,C,C,C,C,H; wait_cnt clears on each H grant.
- H load 0xFF then H load 0x00 after preload (0xFF = 0x11, 0x00 = 0x22) -> h_rdata 0x11 then 0x22, no address carry effects.
- NUM_DOMAINS = 2: C store 0x05 = 16'h1234, H load 0x05 -> h_rdata = 16'h1234, both domain bytes intact.
- Assert reset during ACCESS of a C store -> store_to_mem drops immediately, memory unchanged, no c_gnt/c_rvalid after reset, state IDLE.
